// File: rtl/move_exec_pkg.sv
// Shared definitions for the move executor: direction codes, heading, FSM states, motor encodings.
package move_exec_pkg;

  // Absolute-direction command codes on movement_sel
  localparam logic [3:0] CODE_NONE = 4'b0000;
  localparam logic [3:0] CODE_N    = 4'b0001;
  localparam logic [3:0] CODE_E    = 4'b0011;
  localparam logic [3:0] CODE_S    = 4'b0010;
  localparam logic [3:0] CODE_W    = 4'b0100;

  // Heading, clockwise from north
  typedef logic [1:0] heading_t;
  localparam heading_t HEAD_N = 2'd0;
  localparam heading_t HEAD_E = 2'd1;
  localparam heading_t HEAD_S = 2'd2;
  localparam heading_t HEAD_W = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TURN_R = 2'd1,
    TURN_L = 2'd2,
    FWD    = 2'd3
  } state_t;

  // Motor drive word {en,dir}; dir=1 is forward
  typedef struct packed {
    logic en;
    logic dir;
  } motor_t;

  localparam motor_t MOTOR_OFF = '{en: 1'b0, dir: 1'b0};
  localparam motor_t MOTOR_FWD = '{en: 1'b1, dir: 1'b1};
  localparam motor_t MOTOR_REV = '{en: 1'b1, dir: 1'b0};

  // True for one of the four direction codes
  function automatic logic code_valid(input logic [3:0] code);
    return (code == CODE_N) || (code == CODE_E) || (code == CODE_S) || (code == CODE_W);
  endfunction

  // Map a valid direction code to its heading; anything else maps to north
  function automatic heading_t code_heading(input logic [3:0] code);
    heading_t h;
    case (code)
      CODE_E:  h = HEAD_E;
      CODE_S:  h = HEAD_S;
      CODE_W:  h = HEAD_W;
      default: h = HEAD_N;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/move_pwm_gen.sv
// PWM phase counter plus duty compare. on_c is the enable that applies in the
// cycle after the current edge, so the caller can register it alongside its
// next-state outputs. restart forces phase 0 for that next cycle.
module move_pwm_gen #(
  parameter int unsigned PERIOD = 16,
  parameter int unsigned DUTY   = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic restart,
  output logic on_c
);

  localparam int unsigned PH_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [PH_W-1:0] phase_q;
  logic [PH_W-1:0] phase_d;

  // Next phase: restart wins, otherwise advance and wrap at PERIOD-1
  always_comb begin
    phase_d = phase_q;
    if (restart) begin
      phase_d = '0;
    end else if (enable) begin
      if (phase_q == PH_W'(PERIOD - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
    end
  end

  assign on_c = (32'(phase_d) < DUTY);

  // Phase register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= '0;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/move_executor.sv
// Move executor: turns a robot to an absolute heading with timed quarter
// turns, then drives forward one cell. Optional PWM on the forward move is
// compiled in with MOVE_EXEC_PWM_EN.
module move_executor
  import move_exec_pkg::*;
#(
  parameter int unsigned TURN_CYCLES = 1000,
  parameter int unsigned MOVE_CYCLES = 4000,
  parameter int unsigned PWM_PERIOD  = 16,
  parameter int unsigned PWM_DUTY    = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] movement_sel,
  input  logic       halt,
  output logic [1:0] motor_l,
  output logic [1:0] motor_r,
  output logic [1:0] heading,
  output logic       busy,
  output logic       done,
  output logic       cmd_err
);

  localparam int unsigned MAX_CYCLES = (TURN_CYCLES > MOVE_CYCLES) ? TURN_CYCLES : MOVE_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] TURN_LAST = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] MOVE_LAST = CNT_W'(MOVE_CYCLES - 1);

  // Illegal parameter combinations leave this block empty but named for easy spotting
  if ((TURN_CYCLES == 0) || (MOVE_CYCLES == 0) || (PWM_PERIOD == 0) || (PWM_DUTY > PWM_PERIOD)) begin : g_bad_cfg
  end

  state_t           state_q;
  state_t           state_d;
  heading_t         head_q;
  heading_t         head_d;
  logic [1:0]       quart_q;
  logic [1:0]       quart_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  heading_t         target;
  heading_t         diff;
  logic             done_d;
  logic             err_d;
  logic             busy_d;
  motor_t           ml_d;
  motor_t           mr_d;
  logic             fwd_en_c;

`ifdef MOVE_EXEC_PWM_EN
  logic fwd_entry_c;
  logic fwd_next_c;

  assign fwd_next_c  = (state_d == FWD);
  assign fwd_entry_c = (state_d == FWD) && (state_q != FWD);

  move_pwm_gen #(
    .PERIOD (PWM_PERIOD),
    .DUTY   (PWM_DUTY)
  ) u_pwm (
    .clk     (clk),
    .rst     (rst),
    .enable  (fwd_next_c),
    .restart (fwd_entry_c),
    .on_c    (fwd_en_c)
  );
`else
  assign fwd_en_c = 1'b1;
`endif

  // Next-state, heading, quarter count and cycle counter
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    quart_d = quart_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    target  = code_heading(movement_sel);
    diff    = target - head_q;

    if (halt) begin
      state_d = IDLE;
      quart_d = 2'd0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (code_valid(movement_sel)) begin
            cnt_d = '0;
            case (diff)
              2'd0: begin state_d = FWD;    quart_d = 2'd0; end
              2'd1: begin state_d = TURN_R; quart_d = 2'd1; end
              2'd2: begin state_d = TURN_R; quart_d = 2'd2; end
              default: begin state_d = TURN_L; quart_d = 2'd1; end
            endcase
          end else if (movement_sel != CODE_NONE) begin
            err_d = 1'b1;
          end
        end
        TURN_R, TURN_L: begin
          if (cnt_q == TURN_LAST) begin
            head_d  = (state_q == TURN_R) ? head_q + 2'd1 : head_q - 2'd1;
            quart_d = quart_q - 2'd1;
            cnt_d   = '0;
            if (quart_q == 2'd1) begin
              state_d = FWD;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        FWD: begin
          if (cnt_q == MOVE_LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = IDLE;
          quart_d = 2'd0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Motor drive and busy for the upcoming state
  always_comb begin
    ml_d   = MOTOR_OFF;
    mr_d   = MOTOR_OFF;
    busy_d = (state_d != IDLE);
    case (state_d)
      TURN_R: begin ml_d = MOTOR_FWD; mr_d = MOTOR_REV; end
      TURN_L: begin ml_d = MOTOR_REV; mr_d = MOTOR_FWD; end
      FWD: begin
        ml_d = '{en: fwd_en_c, dir: 1'b1};
        mr_d = '{en: fwd_en_c, dir: 1'b1};
      end
      default: begin ml_d = MOTOR_OFF; mr_d = MOTOR_OFF; end
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      head_q  <= HEAD_N;
      quart_q <= 2'd0;
      cnt_q   <= '0;
      motor_l <= MOTOR_OFF;
      motor_r <= MOTOR_OFF;
      busy    <= 1'b0;
      done    <= 1'b0;
      cmd_err <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      quart_q <= quart_d;
      cnt_q   <= cnt_d;
      motor_l <= ml_d;
      motor_r <= mr_d;
      busy    <= busy_d;
      done    <= done_d;
      cmd_err <= err_d;
    end
  end

  assign heading = head_q;

endmodule

// File: tb/tb_move_executor.sv
// Directed bench for move_executor with TURN_CYCLES=4, MOVE_CYCLES=8.
module tb_move_executor;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] sel  = 4'b0000;
  logic       halt = 1'b0;
  logic [1:0] motor_l;
  logic [1:0] motor_r;
  logic [1:0] heading;
  logic       busy;
  logic       done;
  logic       cmd_err;

  int total = 0;
  int bad   = 0;

  move_executor #(
    .TURN_CYCLES (4),
    .MOVE_CYCLES (8),
    .PWM_PERIOD  (4),
    .PWM_DUTY    (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .movement_sel (sel),
    .halt         (halt),
    .motor_l      (motor_l),
    .motor_r      (motor_r),
    .heading      (heading),
    .busy         (busy),
    .done         (done),
    .cmd_err      (cmd_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Expected en bit in forward cycle k (0-based)
  function automatic logic fwd_en(input int k);
`ifdef MOVE_EXEC_PWM_EN
    return (k % 4) < 3;
`else
    return (k >= 0);
`endif
  endfunction

  // Wait for done with a cycle bound; returns ticks taken
  task automatic wait_done(output int n);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
  endtask

  // Issue a one-cycle command and check its length and final heading
  task automatic run_cmd(input logic [3:0] code, input int exp_ticks, input int exp_head, input string tag);
    int n;
    sel = code;
    tick(1);
    sel = 4'b0000;
    wait_done(n);
    check({tag, "_len"}, n, exp_ticks);
    check({tag, "_head"}, heading, exp_head);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] bad_codes [3];
    bad_codes[0] = 4'b1111;
    bad_codes[1] = 4'b1000;
    bad_codes[2] = 4'b0101;

    // Reset state
    tick(2);
    check("rst_head", heading, 0);
    check("rst_busy", busy, 0);
    check("rst_ml", motor_l, 0);
    check("rst_mr", motor_r, 0);
    check("rst_done", done, 0);
    check("rst_err", cmd_err, 0);
    rst = 1'b0;
    tick(1);

    // Scenario 1: N from N goes straight to FWD for 8 cycles
    sel = 4'b0001;
    tick(1);
    sel = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      check("s1_ml", motor_l, {fwd_en(i), 1'b1});
      check("s1_mr", motor_r, {fwd_en(i), 1'b1});
      check("s1_busy", busy, 1);
      check("s1_done_early", done, 0);
      tick(1);
    end
    check("s1_done", done, 1);
    check("s1_busy_end", busy, 0);
    check("s1_ml_end", motor_l, 0);
    check("s1_head", heading, 0);
    tick(1);
    check("s1_done_pulse", done, 0);

    // Scenario 2: S from N is two right quarters then FWD
    sel = 4'b0010;
    tick(1);
    sel = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      check("s2_ml_turn", motor_l, 2'b11);
      check("s2_mr_turn", motor_r, 2'b10);
      check("s2_head_turn", heading, i / 4);
      tick(1);
    end
    for (int i = 0; i < 8; i++) begin
      check("s2_ml_fwd", motor_l, {fwd_en(i), 1'b1});
      check("s2_head_fwd", heading, 2);
      check("s2_done_early", done, 0);
      tick(1);
    end
    check("s2_done", done, 1);
    check("s2_head", heading, 2);

    // Back to N from S: two right quarters (S->W->N) plus the move
    run_cmd(4'b0001, 16, 0, "s3_home");

    // Scenario 3: W from N is one left quarter
    sel = 4'b0100;
    tick(1);
    sel = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      check("s3_ml_turn", motor_l, 2'b10);
      check("s3_mr_turn", motor_r, 2'b11);
      check("s3_head_turn", heading, 0);
      tick(1);
    end
    check("s3_head", heading, 3);
    check("s3_ml_fwd", motor_l, {fwd_en(0), 1'b1});
    wait_done(n);
    check("s3_fwd_len", n, 8);

    // Scenario 4: invalid codes in IDLE pulse cmd_err only
    tick(1);
    for (int k = 0; k < 3; k++) begin
      sel = bad_codes[k];
      tick(1);
      sel = 4'b0000;
      check("s4_err", cmd_err, 1);
      check("s4_busy", busy, 0);
      check("s4_ml", motor_l, 0);
      check("s4_mr", motor_r, 0);
      tick(1);
      check("s4_err_pulse", cmd_err, 0);
    end
    // N from W: one right quarter; garbage on sel while busy is ignored
    sel = 4'b0001;
    tick(1);
    n = 0;
    while (done !== 1'b1 && n < 200) begin
      sel = (n % 2 == 0) ? 4'b1111 : 4'b0011;
      check("s4_ign_err", cmd_err, 0);
      check("s4_ign_busy", busy, 1);
      tick(1);
      n++;
    end
    sel = 4'b0000;
    check("s4_len", n, 12);
    check("s4_head", heading, 0);
    check("s4_err_end", cmd_err, 0);

    // Scenario 5: halt at cycle 6 of a two-quarter turn
    tick(1);
    sel = 4'b0010;
    tick(1);
    sel = 4'b0000;
    tick(5);
    check("s5_head_mid", heading, 1);
    check("s5_busy_mid", busy, 1);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    check("s5_busy", busy, 0);
    check("s5_ml", motor_l, 0);
    check("s5_mr", motor_r, 0);
    check("s5_head", heading, 1);
    check("s5_done", done, 0);
    tick(1);
    check("s5_done_after", done, 0);
    // Halt together with a valid accept drops the command
    halt = 1'b1;
    sel  = 4'b0001;
    tick(1);
    check("s5_hacc_busy", busy, 0);
    check("s5_hacc_ml", motor_l, 0);
    halt = 1'b0;
    sel  = 4'b0000;
    tick(1);
    check("s5_hacc_busy2", busy, 0);
    check("s5_hacc_head", heading, 1);

    // Held valid code is re-accepted right after done
    sel = 4'b0011;
    tick(1);
    wait_done(n);
    check("b2b_len1", n, 8);
    check("b2b_busy_idle", busy, 0);
    tick(1);
    sel = 4'b0000;
    check("b2b_busy", busy, 1);
    check("b2b_done", done, 0);
    check("b2b_ml", motor_l, {fwd_en(0), 1'b1});
    wait_done(n);
    check("b2b_len2", n, 8);
    check("b2b_head", heading, 1);

    // Asynchronous reset mid-turn restores heading N and clears outputs
    tick(1);
    sel = 4'b0100;
    tick(1);
    sel = 4'b0000;
    tick(5);
    check("rmid_head_pre", heading, 2);
    #2;
    rst = 1'b1;
    #1;
    check("rmid_head", heading, 0);
    check("rmid_busy", busy, 0);
    check("rmid_ml", motor_l, 0);
    check("rmid_mr", motor_r, 0);
    tick(1);
    rst = 1'b0;
    tick(1);
    run_cmd(4'b0001, 8, 0, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/move_executor.md
MOVE_EXECUTOR -- requirements
Module: move_executor

Interface
REQ-001 Parameter TURN_CYCLES, default 1000, the clock cycles per 90-degree turn (minimum 1).
REQ-002 Parameter MOVE_CYCLES, default 4000, the clock cycles per one-cell forward move (minimum 1).
REQ-003 Parameter PWM_PERIOD, default 16, and parameter PWM_DUTY, default 12, SHALL set the PWM period and high cycles when PWM is compiled in; PWM_DUTY SHALL be at most PWM_PERIOD.
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high. The ports are:
- clk  in  1  clock.
- rst  in  1  asynchronous reset, active-high.
- movement_sel  in  4  absolute-direction command: 0001=N, 0011=E, 0010=S, 0100=W, 0000=none.
- halt  in  1  synchronous abort.
- motor_l  out  2  left motor {en,dir}; dir=1 means forward.
- motor_r  out  2  right motor {en,dir}.
- heading  out  2  current heading: 0=N, 1=E, 2=S, 3=W.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  single-cycle pulse when a move completes.
- cmd_err  out  1  single-cycle pulse when an invalid code is received.

Function
REQ-005 The block SHALL use the states IDLE, TURN_R, TURN_L and FWD; all outputs SHALL be registered.
REQ-006 In IDLE with halt=0, a valid nonzero code SHALL be accepted at the clock edge; with diff=(target-heading) mod 4, the next state SHALL be: diff 0 -> FWD; diff 1 -> TURN_R (1 quarter turn); diff 2 -> TURN_R (2 quarter turns); diff 3 -> TURN_L (1 quarter turn).
REQ-007 In IDLE, a nonzero code outside the four valid codes SHALL pulse cmd_err for 1 cycle and leave the state in IDLE with motors off.
REQ-008 Outside IDLE, movement_sel SHALL be ignored: no queueing and no cmd_err.
REQ-009 Each quarter turn SHALL last exactly TURN_CYCLES cycles; at the end of each quarter, heading SHALL update (+1 for right, -1 for left, mod 4) and the remaining-quarter count SHALL decrement; when the count reaches 0 the next state SHALL be FWD.
REQ-010 FWD SHALL last exactly MOVE_CYCLES cycles and then return to IDLE; done SHALL be 1 in the first IDLE cycle.
REQ-011 Motor outputs SHALL be: TURN_R motor_l=11, motor_r=10; TURN_L motor_l=10, motor_r=11; FWD both 11; IDLE both 00.
REQ-012 Motor outputs SHALL reflect the new state in the cycle after acceptance, with 1-cycle latency.
REQ-013 When halt=1 in any state, the next state SHALL be IDLE with motors 00 and counters cleared; done SHALL NOT pulse, and heading SHALL keep the last completed quarter turn.
REQ-014 A halt in the same cycle as a valid accept SHALL win: the command is dropped and busy stays 0.
REQ-015 A valid code held constant after done SHALL be re-accepted on the next IDLE cycle; this back-to-back behaviour is intended.
REQ-016 The cycle counter SHALL be $clog2(max(TURN_CYCLES,MOVE_CYCLES)+1) bits wide, SHALL never wrap, and SHALL reload to 0 on every state entry.

Reset
REQ-017 While rst=1 (asynchronous), the block SHALL hold: state=IDLE, heading=0 (N), counters=0, motor_l=motor_r=00, busy=0, done=0, cmd_err=0.
REQ-018 A reset asserted mid-turn or mid-move SHALL discard the command and restore heading to N.

Configuration
REQ-019 With MOVE_EXEC_PWM_EN defined, the en bits during FWD SHALL be gated by the PWM (high for PWM_DUTY of every PWM_PERIOD cycles, restarting at FWD entry), and turns SHALL stay at full enable.
REQ-020 Without MOVE_EXEC_PWM_EN, en SHALL be constant 1 in FWD, and no PWM logic SHALL be synthesised.

Structure
REQ-021 Package move_exec_pkg SHALL hold the four direction-code constants, the heading type, the state enum and the motor {en,dir} encodings.
REQ-022 The PWM SHALL be in a separate sub-module, move_pwm_gen (counter plus compare, with enable/restart input), instantiated only under MOVE_EXEC_PWM_EN.

Verification (TURN_CYCLES=4, MOVE_CYCLES=8, PWM off unless stated)
REQ-023 Scenario 1: reset, then sel=0001 for 1 cycle -> FWD for 8 cycles with motors 11/11, done at cycle 9, heading=0.
REQ-024 Scenario 2: heading N, sel=0010 -> TURN_R for 8 cycles, heading 1 after 4 cycles and 2 after 8, then FWD 8 cycles, then done.
REQ-025 Scenario 3: heading N, sel=0100 -> TURN_L 4 cycles with motor_l=10 and motor_r=11, heading=3, then FWD.
REQ-026 Scenario 4: sel=1111 in IDLE -> cmd_err pulse, busy=0, motors 00; sel changed during busy -> ignored.
REQ-027 Scenario 5: halt at cycle 6 of a 2-quarter turn -> IDLE next cycle, heading=1, no done; halt together with accept -> busy stays 0.
REQ-028 Scenario 6: with MOVE_EXEC_PWM_EN, PWM_PERIOD=4 and PWM_DUTY=3 -> en in FWD follows 1,1,1,0 repeating; rst asserted mid-FWD -> all outputs 0 immediately.
